// File: rtl/wb_uart_if.sv
// if_wb: 16-bit Wishbone bus bundle between the J1 data bus and I/O slaves.
// Signals: adr, wdat (to slave), rdat (from slave), we, cyc, stb, ack.
interface if_wb;
  logic [15:0] adr;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport master (
    output adr, wdat, we, cyc, stb,
    input  rdat, ack
  );

  modport slave (
    input  adr, wdat, we, cyc, stb,
    output rdat, ack
  );
endinterface

// File: rtl/wb_uart.sv
// wb_uart: Wishbone UART, TX/RX FIFOs, 8N1 frames, polled or irq-driven I/O.
// Ports: clk, reset_n, wb (if_wb.slave), rxd, txd, irq. Option: UART_LOOPBACK_EN.
module wb_uart #(
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic clk,
  input  logic reset_n,
  if_wb.slave  wb,
  input  logic rxd,
  output logic txd,
  output logic irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } st_t;

  logic ack, acc, wr, rd;
  logic unused_adr;
  assign acc = wb.cyc & wb.stb & ack;
  assign wr  = acc & wb.we;
  assign rd  = acc & ~wb.we;
  assign unused_adr = ^wb.adr[15:2];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ack <= 1'b0;
    else          ack <= wb.cyc & wb.stb & ~ack;
  assign wb.ack = ack;

  logic [15:0] div;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) div <= DIV_RESET;
    else if (wr && wb.adr[1:0] == 2'd2)
      div <= (wb.wdat < 16'd3) ? 16'd3 : wb.wdat;

  // TX FIFO
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wp, tx_rp;
  logic tx_empty, tx_full, tx_push, tx_pop;
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) &&
                    (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign tx_push  = wr && wb.adr[1:0] == 2'd0 && !tx_full;

  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= wb.wdat[7:0];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end

  // TX serialiser
  st_t         tx_st, tx_nx;
  logic [15:0] tx_cnt, tx_cnt_nx;
  logic [2:0]  tx_idx, tx_idx_nx;
  logic [7:0]  tx_sh, tx_sh_nx;
  logic        tx_line, tx_line_nx, tx_tick;
  assign tx_tick = tx_cnt == 16'd0;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_st   <= S_IDLE;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sh   <= '0;
      tx_line <= 1'b1;
    end else begin
      tx_st   <= tx_nx;
      tx_cnt  <= tx_cnt_nx;
      tx_idx  <= tx_idx_nx;
      tx_sh   <= tx_sh_nx;
      tx_line <= tx_line_nx;
    end

  always_comb begin
    tx_nx     = tx_st;
    tx_cnt_nx = tx_cnt - 16'd1;
    tx_idx_nx = tx_idx;
    tx_sh_nx  = tx_sh;
    tx_pop    = 1'b0;
    unique case (tx_st)
      S_IDLE: begin
        tx_cnt_nx = tx_cnt;
        if (!tx_empty) begin
          tx_nx     = S_START;
          tx_pop    = 1'b1;
          tx_sh_nx  = tx_mem[tx_rp[TAW-1:0]];
          tx_cnt_nx = div;
        end
      end
      S_START:
        if (tx_tick) begin
          tx_nx     = S_DATA;
          tx_idx_nx = 3'd0;
          tx_cnt_nx = div;
        end
      S_DATA:
        if (tx_tick) begin
          tx_cnt_nx = div;
          tx_sh_nx  = tx_sh >> 1;
          tx_idx_nx = tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_nx = S_STOP;
        end
      S_STOP:
        if (tx_tick) begin
          tx_cnt_nx = div;
          if (!tx_empty) begin
            tx_nx    = S_START;
            tx_pop   = 1'b1;
            tx_sh_nx = tx_mem[tx_rp[TAW-1:0]];
          end else begin
            tx_nx = S_IDLE;
          end
        end
      default: tx_nx = S_IDLE;
    endcase
    // registered line level follows the next state, so it lines up with it
    tx_line_nx = (tx_nx == S_START) ? 1'b0 :
                 (tx_nx == S_DATA)  ? tx_sh_nx[0] : 1'b1;
  end

  // RX input path
  logic rx_s1, rx_s2, rx_in, rx_prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_in;
    end

`ifdef UART_LOOPBACK_EN
  logic lb;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lb <= 1'b0;
    else if (wr && wb.adr[1:0] == 2'd3) lb <= wb.wdat[0];
  assign rx_in = lb ? tx_line : rx_s2;
  assign txd   = lb ? 1'b1 : tx_line;
`else
  assign rx_in = rx_s2;
  assign txd   = tx_line;
`endif

  // RX FIFO
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wp, rx_rp;
  logic rx_empty, rx_full, rx_push, rx_pop, rx_req;
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) &&
                    (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign rx_pop   = rd && wb.adr[1:0] == 2'd0 && !rx_empty;
  // a pop in the same cycle frees the slot the new byte lands in
  assign rx_push  = rx_req && (!rx_full || rx_pop);

  // RX deserialiser
  st_t         rx_st, rx_nx;
  logic [15:0] rx_cnt, rx_cnt_nx, rx_half;
  logic [2:0]  rx_idx, rx_idx_nx;
  logic [7:0]  rx_sh, rx_sh_nx;
  logic        rx_tick, ferr_set, ovr_set;
  assign rx_tick = rx_cnt == 16'd0;
  assign rx_half = {1'b0, div[15:1]} + {15'd0, div[0]};
  assign ovr_set = rx_req && rx_full && !rx_pop;

  always_ff @(posedge clk)
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_sh;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_st  <= S_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_st  <= rx_nx;
      rx_cnt <= rx_cnt_nx;
      rx_idx <= rx_idx_nx;
      rx_sh  <= rx_sh_nx;
    end

  always_comb begin
    rx_nx     = rx_st;
    rx_cnt_nx = rx_cnt - 16'd1;
    rx_idx_nx = rx_idx;
    rx_sh_nx  = rx_sh;
    rx_req    = 1'b0;
    ferr_set  = 1'b0;
    unique case (rx_st)
      S_IDLE: begin
        rx_cnt_nx = rx_cnt;
        if (rx_prev && !rx_in) begin
          rx_nx     = S_START;
          rx_cnt_nx = rx_half - 16'd1;
        end
      end
      S_START:
        if (rx_tick) begin
          rx_nx     = rx_in ? S_IDLE : S_DATA;
          rx_cnt_nx = div;
          rx_idx_nx = 3'd0;
        end
      S_DATA:
        if (rx_tick) begin
          rx_cnt_nx = div;
          rx_sh_nx  = {rx_in, rx_sh[7:1]};
          rx_idx_nx = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_nx = S_STOP;
        end
      S_STOP:
        if (rx_tick) begin
          if (rx_in) begin
            rx_req = 1'b1;
            rx_nx  = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            rx_nx    = S_BREAK;
          end
        end
      S_BREAK: begin
        rx_cnt_nx = rx_cnt;
        if (rx_in) rx_nx = S_IDLE;
      end
      default: rx_nx = S_IDLE;
    endcase
  end

  // sticky flags; a STATUS read returns them, then clears
  logic ovr, ferr, st_clr;
  assign st_clr = rd && wb.adr[1:0] == 2'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= (ovr & ~st_clr) | ovr_set;
      ferr <= (ferr & ~st_clr) | ferr_set;
    end

  logic        tx_idle;
  logic [15:0] rmux;
  assign tx_idle = tx_empty && tx_st == S_IDLE;

  always_comb begin
    rmux = 16'h0000;
    unique case (wb.adr[1:0])
      2'd0: rmux = rx_empty ? 16'h0000 :
                   {8'h00, rx_mem[rx_rp[RAW-1:0]]};
      2'd1: rmux = {11'd0, ferr, tx_idle, ovr, tx_full, ~rx_empty};
      2'd2: rmux = div;
`ifdef UART_LOOPBACK_EN
      2'd3: rmux = {15'd0, lb};
`else
      2'd3: rmux = 16'h0000;
`endif
      default: rmux = 16'h0000;
    endcase
  end

  assign wb.rdat = ack ? rmux : 16'h0000;
  assign irq     = ~rx_empty;
endmodule

// File: tb/tb_wb_uart.sv
// tb_wb_uart: directed bench for wb_uart with a queue-based reference model.
// Drives the Wishbone bus and rxd, checks txd, irq and read data.
module tb_wb_uart;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rxd = 1'b1;
  logic txd, irq;

  if_wb bus ();

  wb_uart dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (bus),
    .rxd     (rxd),
    .txd     (txd),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] rx_q[$];
  logic m_ovr  = 1'b0;
  logic m_ferr = 1'b0;
  logic irq_chk = 1'b0;
  logic txd_chk = 1'b0;
  logic txd_exp = 1'b1;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] stat_exp();
    return {11'd0, m_ferr, 1'b1, m_ovr, 1'b0, rx_q.size() != 0};
  endfunction

  always @(negedge clk)
    if (reset_n) begin
      if (!bus.ack) chk("rdat_idle", bus.rdat, 16'h0000);
      if (irq_chk)  chk("irq", {15'd0, irq}, {15'd0, rx_q.size() != 0});
      if (txd_chk)  chk("txd", {15'd0, txd}, {15'd0, txd_exp});
    end

  task automatic bus_xfer(input logic [1:0] a, input logic w,
                          input logic [15:0] d, output logic [15:0] q);
    int n;
    @(negedge clk);
    bus.adr  = {14'd0, a};
    bus.wdat = d;
    bus.we   = w;
    bus.cyc  = 1'b1;
    bus.stb  = 1'b1;
    n = 0;
    @(posedge clk); #1;
    while (!bus.ack && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got 0 expected 1");
    end
    q = bus.rdat;
    @(posedge clk); #1;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] q;
    bus_xfer(a, 1'b1, d, q);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a,
                        input logic [15:0] exp);
    logic [15:0] q;
    bus_xfer(a, 1'b0, 16'h0, q);
    chk(nm, q, exp);
    if (a == 2'd1) begin
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end
    if (a == 2'd0 && rx_q.size() != 0) void'(rx_q.pop_front());
  endtask

  task automatic rd_data(input string nm);
    logic [15:0] e;
    e = (rx_q.size() != 0) ? {8'h00, rx_q[0]} : 16'h0000;
    rd_chk(nm, 2'd0, e);
  endtask

  // one 8N1 frame on rxd at 4 clocks per bit
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    irq_chk = 1'b0;
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        rxd = f[k];
      end
    @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    if (!stop) m_ferr = 1'b1;
    else if (rx_q.size() < 16) rx_q.push_back(b);
    else m_ovr = 1'b1;
    irq_chk = 1'b1;
  endtask

  int ack_pat[6] = '{1, 0, 1, 0, 1, 0};

  initial begin
    logic [9:0] fr;
    int n;
    bus.adr = '0; bus.wdat = '0; bus.we = 0; bus.cyc = 0; bus.stb = 0;
    repeat (3) @(negedge clk);
    chk("rst_txd", {15'd0, txd}, 16'd1);
    chk("rst_irq", {15'd0, irq}, 16'd0);
    reset_n = 1'b1;
    irq_chk = 1'b1;
    @(negedge clk);
    chk("rst_ack", {15'd0, bus.ack}, 16'd0);
    chk("model_rst", stat_exp(), 16'h0008);
    rd_chk("rst_status", 2'd1, 16'h0008);
    rd_chk("rst_div", 2'd2, 16'd433);
    rd_chk("rst_data", 2'd0, 16'h0000);
    rd_chk("rst_ctrl", 2'd3, 16'h0000);

    // stb held high: ack pulses every other cycle
    @(negedge clk);
    bus.adr = 16'd1; bus.cyc = 1; bus.stb = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ack_alt", {15'd0, bus.ack}, 16'(ack_pat[i]));
    end
    bus.cyc = 0; bus.stb = 0;

    wr(2'd2, 16'd1);
    rd_chk("div_min", 2'd2, 16'd3);
    wr(2'd2, 16'd3);
    rd_chk("div_3", 2'd2, 16'd3);

    // TX frame 0xA5, each bit exactly 4 clocks
    fr = {1'b1, 8'hA5, 1'b0};
    wr(2'd0, 16'h00A5);
    txd_exp = 1'b1;
    txd_chk = 1'b1;
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        txd_exp = fr[k];
      end
    @(posedge clk);
    txd_exp = 1'b1;
    repeat (3) @(posedge clk);
    txd_chk = 1'b0;
    rd_chk("tx_idle", 2'd1, 16'h0008);

    // RX frame 0x3C
    rx_frame(8'h3C, 1'b1);
    chk("rx_irq", {15'd0, irq}, 16'd1);
    chk("model_rx", stat_exp(), 16'h0009);
    rd_chk("rx_status", 2'd1, stat_exp());
    rd_chk("rx_data", 2'd0, 16'h003C);
    @(negedge clk);
    chk("rx_irq_pop", {15'd0, irq}, 16'd0);
    rd_data("rx_empty");

    // RX overrun
    for (int i = 0; i < 17; i++) begin
      rx_frame(8'(i * 37 + 5), 1'b1);
      repeat (2) @(negedge clk);
    end
    chk("model_ovr", stat_exp(), 16'h000D);
    rd_chk("ovr_status", 2'd1, stat_exp());
    for (int i = 0; i < 16; i++) rd_data("ovr_data");
    rd_chk("ovr_clear", 2'd1, 16'h0008);

    // frame error, then glitch
    rx_frame(8'h3C, 1'b0);
    chk("model_ferr", stat_exp(), 16'h0018);
    rd_chk("ferr_status", 2'd1, stat_exp());
    rd_chk("ferr_clear", 2'd1, 16'h0008);
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("glitch_status", 2'd1, 16'h0008);
    rd_data("glitch_data");

`ifdef UART_LOOPBACK_EN
    wr(2'd3, 16'h0001);
    rd_chk("ctrl_lb", 2'd3, 16'h0001);
    txd_exp = 1'b1;
    txd_chk = 1'b1;
    irq_chk = 1'b0;
    wr(2'd0, 16'h005A);
    repeat (60) @(negedge clk);
    rx_q.push_back(8'h5A);
    irq_chk = 1'b1;
    rd_chk("lb_data", 2'd0, 16'h005A);
    txd_chk = 1'b0;
    wr(2'd3, 16'h0000);
`else
    wr(2'd3, 16'h0001);
    rd_chk("ctrl_none", 2'd3, 16'h0000);
`endif

    // reset in the middle of a frame
    wr(2'd0, 16'h0000);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_start", {15'd0, txd}, 16'd0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_txd", {15'd0, txd}, 16'd1);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("mid_rst_div", 2'd2, 16'd433);
    rd_chk("mid_rst_stat", 2'd1, 16'h0008);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_uart.md
Name: wb_uart

Overview:
- Wishbone slave UART on the J1 CPU's data bus, selected by the system address decoder for the I/O window.
- CPU stores push bytes into a TX FIFO, which a serialiser sends as 8N1 frames.
- A deserialiser fills an RX FIFO that the CPU drains with loads.
- Status, divisor and optional control registers give polled or interrupt-driven I/O.

Parameters:
- TX_DEPTH, 16: TX FIFO entries; power of 2, at least 2.
- RX_DEPTH, 16: RX FIFO entries; power of 2, at least 2.
- DIV_RESET, 16'd433: reset value of DIVISOR. Bit period = DIVISOR+1 clocks (433 gives 115200 baud at 50 MHz).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- wb  if_wb.slave  -  Wishbone bus: adr[15:0], dat 16 each way, we, cyc, stb, ack.
- rxd  in  1  serial input, asynchronous.
- txd  out  1  serial output, idle high.
- irq  out  1  high while RX FIFO is not empty.

Behaviour:
- Reset: txd=1, ack=0, irq=0, read data=0, both FIFOs empty, sticky flags 0, DIVISOR=DIV_RESET, both FSMs IDLE.
  - Reset mid-frame aborts immediately; txd returns to 1 asynchronously.
- Decode uses wb.adr[1:0] only:
  - 0 DATA. Read returns {8'h00, RX head} and pops. Write pushes dat[7:0].
  - 1 STATUS (read-only): bit0 rx_avail, bit1 tx_full, bit2 rx_overrun (sticky), bit3 tx_idle (FIFO empty and serialiser IDLE), bit4 frame_err (sticky), other bits 0.
  - 2 DIVISOR: read/write, 16 bits.
  - 3 CONTROL: see Optional Feature.
- Handshake: ack <= cyc & stb & ~ack (registered).
  - Every access takes 2 cycles; with stb held high, ack pulses every other cycle.
  - Side effects (push, pop, flag clear, register write) happen only in a cycle where cyc & stb & ack, so exactly once per transaction.
  - Read data is valid only while ack=1, and is 0 otherwise.
  - A STATUS read clears rx_overrun and frame_err at the end of the ack cycle. The returned value shows the flags as they were before clearing.
- Edge cases:
  - DATA read with RX empty returns 16'h0000 and does not pop.
  - DATA write with TX full is dropped.
  - DIVISOR write below 3 stores 3.
- FIFOs: circular buffers with pointer width log2(DEPTH)+1.
  - Full/empty come from the MSB compare.
  - Pointers wrap at DEPTH.
  - Simultaneous push and pop on the same FIFO is legal; count is unchanged. On RX, a pop in the same cycle as a push into a full FIFO keeps the new byte and sets no overrun.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state lasts DIVISOR+1 clocks, timed by a bit counter reloaded at each bit boundary.
  - Leaves IDLE the cycle after the FIFO is non-empty, popping the head into a shift register.
  - Back-to-back frames: STOP goes straight to START if the FIFO is non-empty.
  - A DIVISOR change takes effect at the next bit boundary.
- RX path: rxd passes a 2-FF synchroniser (2 cycles latency) before any use.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge of the synchronised input enters START.
  - START: sample at (DIVISOR+1)/2 clocks. High means a glitch, return to IDLE; low means proceed.
  - DATA: 8 samples, one per bit period at mid-bit.
  - STOP: sampled at mid-bit.
    - Stop high with FIFO not full: push the byte.
    - Stop high with FIFO full: drop the byte and set rx_overrun.
    - Stop low: drop the byte, set frame_err, and wait for input high before IDLE.
- irq is combinational from ~rx_empty.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - CONTROL register at address 3, bit0 = loopback, reset 0.
  - With loopback=1, the receiver input is the internal serialiser output instead of synchronised rxd, and the external txd is forced to 1.
  - Toggling loopback mid-frame may corrupt that frame; no other side effect.
- Not defined: address 3 reads 16'h0000, writes are ignored, and no loopback logic exists.

Test Plan:
- Reset then read each address -> STATUS=16'h0008, DIVISOR=16'd433, DATA=16'h0000, txd=1, irq=0. With stb held, ack alternates 0/1.
- DIVISOR=3, write DATA 16'h00A5 -> txd shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 clocks; STATUS bit3 returns to 1 after the stop bit.
- DIVISOR=3, drive rxd frame 0x3C at 4 clocks/bit -> irq rises after the stop sample; DATA read = 16'h003C; irq falls after the pop.
- Drive RX_DEPTH+1 frames without reading -> STATUS bit2=1; first 16 bytes read back intact; second STATUS read shows bit2=0.
- Drive a frame with stop bit low -> STATUS bit4=1, no push. A 1-cycle low glitch on rxd produces no push and no error.
- With UART_LOOPBACK_EN: CONTROL=1, write DATA 16'h005A -> DATA read returns 16'h005A and txd stays 1 throughout. Without the macro, CONTROL reads 16'h0000.
